// File: rtl/fat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fat_pkg : scanner FSM encoding and FAT directory constants. Rev 1.0 |
// +--------------------------------------------------------------------+
package fat_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   localparam int         ENTRY_BYTES = 32;
   localparam int         SEC_BYTES   = 512;
   localparam int         NAME_MAX    = 52;
   localparam logic [7:0] DIR_END     = 8'h00;

endpackage
`default_nettype wire

// File: rtl/fat_name_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fat_name_cmp : length + byte-wise compare of two names. Rev 1.0     |
// +--------------------------------------------------------------------+
module fat_name_cmp #(
   parameter int NAME_MAX = fat_pkg::NAME_MAX
) (
   input  logic [7:0]                len_a,
   input  logic [NAME_MAX-1:0][7:0] name_a,
   input  logic [7:0]                len_b,
   input  logic [NAME_MAX-1:0][7:0] name_b,
   output logic                      hit
);

   // Only the first len_a bytes take part; trailing bytes are don't-care.
   always_comb begin
      hit = (len_a == len_b);
      for (int i = 0; i < NAME_MAX; i++) begin
         if ((32'(i) < 32'(len_a)) && (name_a[i] != name_b[i])) begin
            hit = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fat_dir_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fat_dir_scanner : FAT root-directory search sequencer. Rev 1.0      |
// +--------------------------------------------------------------------+
module fat_dir_scanner #(
   parameter int NAME_MAX  = fat_pkg::NAME_MAX,
   parameter int SEC_BYTES = fat_pkg::SEC_BYTES
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [31:0]               root_lba,
   input  logic [15:0]               root_secs,
   input  logic [NAME_MAX-1:0][7:0] tgt_name,
   input  logic [7:0]                tgt_len,
   output logic                      sec_req,
   output logic [31:0]               sec_lba,
   input  logic                      sec_ack,
   input  logic                      sd_rvalid,
   input  logic [7:0]                sd_rdata,
   input  logic                      sd_done,
   output logic                      p_rvalid,
   output logic [4:0]                p_raddr,
   output logic [7:0]                p_rdata,
   input  logic                      p_fready,
   input  logic [7:0]                p_fnamelen,
   input  logic [NAME_MAX-1:0][7:0] p_fname,
   input  logic [15:0]               p_fcluster,
   input  logic [31:0]               p_fsize,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [15:0]               file_cluster,
   output logic [31:0]               file_size
);

   import fat_pkg::*;

   localparam int CNT_W = $clog2(SEC_BYTES);
   localparam int OFF_W = $clog2(ENTRY_BYTES);

   state_t                    state;
   logic [31:0]               base_lba;
   logic [15:0]               n_secs;
   logic [NAME_MAX-1:0][7:0] name_q;
   logic [7:0]                len_q;
   logic [15:0]               sec_idx;
   logic [CNT_W-1:0]          byte_cnt;
   logic                      eod;
   logic                      sec_full;
   logic                      hit;
   logic                      entry_start;
   logic                      last_sec;
   logic                      match;

   fat_name_cmp #(
      .NAME_MAX (NAME_MAX)
   ) u_name_cmp (
      .len_a  (len_q),
      .name_a (name_q),
      .len_b  (p_fnamelen),
      .name_b (p_fname),
      .hit    (hit)
   );

   assign entry_start = (byte_cnt[OFF_W-1:0] == '0);
   assign last_sec    = ((sec_idx + 16'd1) == n_secs);
   assign match       = p_fready && hit;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= ST_IDLE;
         base_lba     <= '0;
         n_secs       <= '0;
         name_q       <= '0;
         len_q        <= '0;
         sec_idx      <= '0;
         byte_cnt     <= '0;
         eod          <= 1'b0;
         sec_full     <= 1'b0;
         sec_req      <= 1'b0;
         sec_lba      <= '0;
         p_rvalid     <= 1'b0;
         p_raddr      <= '0;
         p_rdata      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         found        <= 1'b0;
         file_cluster <= '0;
         file_size    <= '0;
      end else begin
         done     <= 1'b0;
         p_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_lba     <= root_lba;
                  n_secs       <= root_secs;
                  name_q       <= tgt_name;
                  len_q        <= tgt_len;
                  found        <= 1'b0;
                  file_cluster <= '0;
                  file_size    <= '0;
                  sec_idx      <= '0;
                  byte_cnt     <= '0;
                  eod          <= 1'b0;
                  sec_full     <= 1'b0;
                  busy         <= 1'b1;
                  if (root_secs == 16'd0) begin
                     state <= ST_FINISH;
                  end else begin
                     state   <= ST_REQ;
                     sec_req <= 1'b1;
                     sec_lba <= root_lba;
                  end
               end
            end

            ST_REQ: begin
               if (sec_ack) begin
                  sec_req <= 1'b0;
                  state   <= ST_STREAM;
               end
            end

            ST_STREAM: begin
               // Bytes keep being counted after end-of-directory so offsets stay aligned.
               if (sd_rvalid) begin
                  p_rvalid <= !eod && !sec_full && !match;
                  p_rdata  <= sd_rdata;
                  p_raddr  <= byte_cnt[OFF_W-1:0];
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == CNT_W'(SEC_BYTES - 1)) begin
                     sec_full <= 1'b1;
                  end
                  if (entry_start && (sd_rdata == DIR_END)) begin
                     eod <= 1'b1;
                  end
               end
               if (match) begin
                  found        <= 1'b1;
                  file_cluster <= p_fcluster;
                  file_size    <= p_fsize;
                  state        <= sd_done ? ST_FINISH : ST_DRAIN;
               end else if (sd_done) begin
                  if (eod || last_sec) begin
                     state <= ST_FINISH;
                  end else begin
                     sec_idx  <= sec_idx + 16'd1;
                     byte_cnt <= '0;
                     sec_full <= 1'b0;
                     sec_req  <= 1'b1;
                     sec_lba  <= base_lba + {16'd0, sec_idx} + 32'd1;
                     state    <= ST_REQ;
                  end
               end
            end

            ST_DRAIN: begin
               if (sd_done) begin
                  state <= ST_FINISH;
               end
            end

            ST_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               sec_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fat_dir_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fat_dir_scanner : directed table-driven bench for the scanner.  |
// +--------------------------------------------------------------------+
module tb_fat_dir_scanner;

   localparam int NM = 52;
   typedef logic [NM-1:0][7:0] name_t;

   typedef struct {
      logic [31:0] lba;
      int          secs;
      name_t       tname;
      logic [7:0]  tlen;
      name_t       dname;
      logic [7:0]  dlen;
      int          hit_sec;
      int          hit_ent;
      int          eod_sec;
      int          eod_ent;
      logic [15:0] clus;
      logic [31:0] fsz;
      int          exp_reqs;
      bit          exp_found;
      int          exp_fwd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] root_lba = '0;
   logic [15:0] root_secs = '0;
   name_t       tgt_name = '0;
   logic [7:0]  tgt_len = '0;
   logic        sec_req;
   logic [31:0] sec_lba;
   logic        sec_ack = 1'b0;
   logic        sd_rvalid = 1'b0;
   logic [7:0]  sd_rdata = '0;
   logic        sd_done = 1'b0;
   logic        p_rvalid;
   logic [4:0]  p_raddr;
   logic [7:0]  p_rdata;
   logic        p_fready = 1'b0;
   logic [7:0]  p_fnamelen = '0;
   name_t       p_fname = '0;
   logic [15:0] p_fcluster = '0;
   logic [31:0] p_fsize = '0;
   logic        busy;
   logic        done;
   logic        found;
   logic [15:0] file_cluster;
   logic [31:0] file_size;

   int          checks = 0;
   int          failures = 0;
   int          fwd_cnt = 0;
   int          fwd_err = 0;
   logic [12:0] expq[$];
   logic [12:0] exp_e;
   bit          hit_sent;
   bit          eod_seen;
   vec_t        vecs[7];

   always #5 clk = ~clk;

   fat_dir_scanner dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .root_lba     (root_lba),
      .root_secs    (root_secs),
      .tgt_name     (tgt_name),
      .tgt_len      (tgt_len),
      .sec_req      (sec_req),
      .sec_lba      (sec_lba),
      .sec_ack      (sec_ack),
      .sd_rvalid    (sd_rvalid),
      .sd_rdata     (sd_rdata),
      .sd_done      (sd_done),
      .p_rvalid     (p_rvalid),
      .p_raddr      (p_raddr),
      .p_rdata      (p_rdata),
      .p_fready     (p_fready),
      .p_fnamelen   (p_fnamelen),
      .p_fname      (p_fname),
      .p_fcluster   (p_fcluster),
      .p_fsize      (p_fsize),
      .busy         (busy),
      .done         (done),
      .found        (found),
      .file_cluster (file_cluster),
      .file_size    (file_size)
   );

   // Every forwarded byte must match the next expected {offset, data} pair.
   always @(negedge clk) begin
      if (p_rvalid) begin
         fwd_cnt++;
         if (expq.size() == 0) begin
            fwd_err++;
         end else begin
            exp_e = expq.pop_front();
            if ({p_raddr, p_rdata} !== exp_e) fwd_err++;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic name_t mk_name(input string s);
      name_t n;
      n = '0;
      for (int i = 0; i < s.len() && i < NM; i++) n[i] = s[i];
      return n;
   endfunction

   function automatic vec_t mk(input logic [31:0] lba, input int secs, input string tgt,
                               input string dec, input int hs, input int he, input int es,
                               input int ee, input logic [15:0] cl, input logic [31:0] sz,
                               input int reqs, input bit fnd, input int fwd);
      vec_t v;
      v.lba = lba;       v.secs = secs;
      v.tname = mk_name(tgt); v.tlen = 8'(tgt.len());
      v.dname = mk_name(dec); v.dlen = 8'(dec.len());
      v.hit_sec = hs;    v.hit_ent = he;
      v.eod_sec = es;    v.eod_ent = ee;
      v.clus = cl;       v.fsz = sz;
      v.exp_reqs = reqs; v.exp_found = fnd; v.exp_fwd = fwd;
      return v;
   endfunction

   // Parser stand-in: one record per completed entry until end-of-dir or a hit.
   task automatic give_rec(input vec_t v, input int sec, input int e);
      p_fready = 1'b0;
      if (hit_sent || eod_seen) return;
      p_fready = 1'b1;
      if (sec == v.hit_sec && e == v.hit_ent) begin
         p_fname = v.tname; p_fnamelen = v.tlen;
         p_fcluster = v.clus; p_fsize = v.fsz;
         hit_sent = 1'b1;
      end else begin
         p_fname = v.dname; p_fnamelen = v.dlen;
         p_fcluster = 16'h8000 | 16'(sec * 16 + e);
         p_fsize = 32'hCAFE_0000 | 32'(e);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          reqs;
      int          lat;
      int          sec;
      bit          got_done;
      logic [7:0]  d;
      logic [31:0] exp_lba;
      reqs = 0; got_done = 1'b0; lat = 0;
      fwd_cnt = 0; fwd_err = 0; expq.delete();
      hit_sent = 1'b0; eod_seen = 1'b0;
      @(negedge clk);
      root_lba = v.lba; root_secs = 16'(v.secs);
      tgt_name = v.tname; tgt_len = v.tlen; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      lat = 1;
      while (!got_done && reqs <= 6) begin
         for (int t = 0; t < 64 && !done && !sec_req; t++) begin
            @(negedge clk);
            lat++;
         end
         if (done) begin
            got_done = 1'b1;
         end else if (!sec_req) begin
            break;
         end else begin
            reqs++;
            sec = reqs - 1;
            exp_lba = v.lba + 32'(sec);
            chk("sec_lba", sec_lba, exp_lba);
            sec_ack = 1'b1;
            @(negedge clk);
            sec_ack = 1'b0;
            chk("sec_req_drop", sec_req, 0);
            for (int i = 0; i < 512; i++) begin
               d = (sec == v.eod_sec && i == v.eod_ent * 32) ? 8'h00
                   : (8'h80 | {1'b0, 7'(i) ^ 7'(sec)});
               sd_rvalid = 1'b1; sd_rdata = d;
               if (i > 0 && i % 32 == 0) give_rec(v, sec, i / 32 - 1);
               else p_fready = 1'b0;
               if (!hit_sent && !eod_seen) expq.push_back({5'(i), d});
               if (i % 32 == 0 && d == 8'h00) eod_seen = 1'b1;
               @(negedge clk);
            end
            sd_rvalid = 1'b0; sd_done = 1'b1;
            give_rec(v, sec, 15);
            @(negedge clk);
            sd_done = 1'b0; p_fready = 1'b0;
            lat = 1;
         end
      end
      chk("done_seen", got_done, 1);
      chk("sec_req_count", reqs, v.exp_reqs);
      chk("done_latency", lat, 2);
      chk("busy_at_done", busy, 0);
      chk("found", found, v.exp_found);
      chk("file_cluster", file_cluster, v.exp_found ? v.clus : 16'h0);
      chk("file_size", file_size, v.exp_found ? v.fsz : 32'h0);
      chk("fwd_count", fwd_cnt, v.exp_fwd);
      chk("fwd_data_errs", fwd_err, 0);
      chk("fwd_leftover", expq.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("found_held", found, v.exp_found);
   endtask

   initial begin
      int dcnt;
      vecs[0] = mk(32'h0000_0100, 1, "README.TXT", "OTHER.BIN",  0,  3, -1, -1,
                   16'h0005, 32'h0000_1234, 1, 1'b1, 128);
      vecs[1] = mk(32'h0000_2000, 4, "README.TXT", "OTHER.BIN",  2, 15, -1, -1,
                   16'h0ABC, 32'hDEAD_BEEF, 3, 1'b1, 1536);
      vecs[2] = mk(32'h0000_0040, 3, "README.TXT", "OTHER.BIN", -1, -1,  0,  5,
                   16'h0000, 32'h0, 1, 1'b0, 161);
      vecs[3] = mk(32'h0000_0080, 0, "README.TXT", "OTHER.BIN", -1, -1, -1, -1,
                   16'h0000, 32'h0, 0, 1'b0, 0);
      vecs[4] = mk(32'h0000_0300, 2, "README.TX",  "README.TXT", -1, -1, -1, -1,
                   16'h0000, 32'h0, 2, 1'b0, 1024);
      vecs[5] = mk(32'hFFFF_FFFF, 2, "KERNEL.IMG", "OTHER.BIN",  1,  0, -1, -1,
                   16'hBEEF, 32'h0000_0200, 2, 1'b1, 544);
      vecs[6] = mk(32'h0000_0500, 1, "README.TXT", "README.TXS", -1, -1, -1, -1,
                   16'h0000, 32'h0, 1, 1'b0, 512);

      repeat (3) @(negedge clk);
      chk("reset_outs_a", {busy, done, found, sec_req, p_rvalid, p_raddr, p_rdata, file_cluster}, 0);
      chk("reset_outs_b", {sec_lba, file_size}, 0);
      rst_n = 1'b0;

      for (int k = 0; k < 7; k++) run_vec(vecs[k]);

      // Reset in the middle of streaming, then a clean scan.
      @(negedge clk);
      root_lba = 32'h0000_0700; root_secs = 16'd2;
      tgt_name = mk_name("README.TXT"); tgt_len = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 64 && !sec_req; t++) @(negedge clk);
      chk("rst_seq_req", sec_req, 1);
      sec_ack = 1'b1;
      @(negedge clk);
      sec_ack = 1'b0;
      for (int i = 0; i < 40; i++) begin
         sd_rvalid = 1'b1; sd_rdata = 8'h80 | 8'(i);
         @(negedge clk);
      end
      chk("pre_rst_fwd", p_rvalid, 1);
      rst_n = 1'b1;
      #1;
      chk("rst_async_a", {busy, done, found, sec_req, p_rvalid, p_raddr, p_rdata, file_cluster}, 0);
      chk("rst_async_b", {sec_lba, file_size}, 0);
      sd_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      dcnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy || sec_req) dcnt++;
      end
      chk("idle_after_rst", dcnt, 0);
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
